inst_encoder_loader: RTL and testbench

// Encoder side of the instruction decoder: takes symbolic instruction requests (ADD/SUB/AND/OR/XOR/SW/LW/J),

---
 rtl/inst_encoder_loader.sv | 164 ++++++++++++++++
 tb/tb_inst_encoder_loader.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_loader.sv
// Encodes symbolic MIPS instruction requests into 32-bit words and streams them
// into instruction memory at consecutive word addresses during a load session.
module inst_encoder_loader #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned CNT_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [CNT_W-1:0]  count,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [2:0]        req_kind,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [25:0]       req_imm,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] KIND_ADD = 3'd0;
   localparam logic [2:0] KIND_SUB = 3'd1;
   localparam logic [2:0] KIND_AND = 3'd2;
   localparam logic [2:0] KIND_OR  = 3'd3;
   localparam logic [2:0] KIND_XOR = 3'd4;
   localparam logic [2:0] KIND_SW  = 3'd5;
   localparam logic [2:0] KIND_LW  = 3'd6;
   localparam logic [2:0] KIND_J   = 3'd7;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_XOR = 6'h26;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] wr_addr, wr_addr_next;
   logic [CNT_W-1:0]  accept_left, accept_left_next;
   logic [CNT_W-1:0]  write_left, write_left_next;
   logic              req_ready_next;
   logic              imem_we_next;
   logic [ADDR_W-1:0] imem_addr_next;
   logic [31:0]       imem_wdata_next;
   logic              busy_next, done_next, err_next;

   logic              handshake;
   logic [31:0]       enc_word;
   logic              enc_bad;

   assign handshake = req_valid && req_ready;

   // Instruction packing; a memory op whose offset does not fit 16 bits becomes a NOP
   always_comb begin
      enc_word = 32'h0000_0000;
      enc_bad  = 1'b0;
      case (req_kind)
         KIND_ADD: enc_word = {OP_RTYPE, req_rs, req_rt, req_rd, 5'b00000, FN_ADD};
         KIND_SUB: enc_word = {OP_RTYPE, req_rs, req_rt, req_rd, 5'b00000, FN_SUB};
         KIND_AND: enc_word = {OP_RTYPE, req_rs, req_rt, req_rd, 5'b00000, FN_AND};
         KIND_OR:  enc_word = {OP_RTYPE, req_rs, req_rt, req_rd, 5'b00000, FN_OR};
         KIND_XOR: enc_word = {OP_RTYPE, req_rs, req_rt, req_rd, 5'b00000, FN_XOR};
         KIND_SW: begin
            if (req_imm[25:16] != 10'd0) enc_bad = 1'b1;
            else enc_word = {OP_SW, req_rs, req_rt, req_imm[15:0]};
         end
         KIND_LW: begin
            if (req_imm[25:16] != 10'd0) enc_bad = 1'b1;
            else enc_word = {OP_LW, req_rs, req_rt, req_imm[15:0]};
         end
         KIND_J:   enc_word = {OP_J, req_imm};
         default:  enc_word = 32'h0000_0000;
      endcase
   end

   // Session control: write_left counts issued writes so DONE follows the last imem_we cycle
   always_comb begin
      state_next       = state;
      wr_addr_next     = wr_addr;
      accept_left_next = accept_left;
      write_left_next  = write_left;
      err_next         = err;
      imem_we_next     = 1'b0;
      imem_addr_next   = imem_addr;
      imem_wdata_next  = imem_wdata;

      case (state)
         IDLE: begin
            if (start) begin
               wr_addr_next     = base_addr;
               accept_left_next = count;
               write_left_next  = count;
               err_next         = 1'b0;
               state_next       = (count == CNT_W'(0)) ? DONE : LOAD;
            end
         end
         LOAD: begin
            if (imem_we) begin
               write_left_next = write_left - CNT_W'(1);
               if (write_left == CNT_W'(1)) state_next = DONE;
            end
            if (handshake) begin
               imem_we_next     = 1'b1;
               imem_addr_next   = wr_addr;
               imem_wdata_next  = enc_word;
               wr_addr_next     = wr_addr + ADDR_W'(1);
               accept_left_next = accept_left - CNT_W'(1);
               if (enc_bad) err_next = 1'b1;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase

      busy_next      = (state_next != IDLE);
      done_next      = (state_next == DONE);
      req_ready_next = (state_next == LOAD) && (accept_left_next != CNT_W'(0));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         wr_addr     <= '0;
         accept_left <= '0;
         write_left  <= '0;
         req_ready   <= 1'b0;
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= 32'h0000_0000;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_next;
         wr_addr     <= wr_addr_next;
         accept_left <= accept_left_next;
         write_left  <= write_left_next;
         req_ready   <= req_ready_next;
         imem_we     <= imem_we_next;
         imem_addr   <= imem_addr_next;
         imem_wdata  <= imem_wdata_next;
         busy        <= busy_next;
         done        <= done_next;
         err         <= err_next;
      end
   end

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed self-checking bench for inst_encoder_loader with hand-encoded expected words.
module tb_inst_encoder_loader;

   localparam logic [2:0] K_ADD = 3'd0;
   localparam logic [2:0] K_AND = 3'd2;
   localparam logic [2:0] K_OR  = 3'd3;
   localparam logic [2:0] K_XOR = 3'd4;
   localparam logic [2:0] K_SW  = 3'd5;
   localparam logic [2:0] K_LW  = 3'd6;
   localparam logic [2:0] K_J   = 3'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [7:0]  base_addr;
   logic [7:0]  count;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_kind;
   logic [4:0]  req_rs, req_rt, req_rd;
   logic [25:0] req_imm;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        busy, done, err;

   int checks   = 0;
   int failures = 0;

   inst_encoder_loader #(.ADDR_W(8), .CNT_W(8)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd), .req_imm(req_imm),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm);
      req_valid = 1'b1;
      req_kind  = k;
      req_rs    = rs;
      req_rt    = rt;
      req_rd    = rd;
      req_imm   = imm;
   endtask

   task automatic begin_session(input logic [7:0] base, input logic [7:0] n);
      start = 1'b1; base_addr = base; count = n;
      tick();
      start = 1'b0;
   endtask

   task automatic check_write(input string tag, input logic [7:0] addr, input logic [31:0] word);
      check({tag, "_we"}, 32'(imem_we), 32'd1);
      check({tag, "_addr"}, 32'(imem_addr), 32'(addr));
      check({tag, "_data"}, imem_wdata, word);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ready"}, 32'(req_ready), 32'd0);
      check({tag, "_we"}, 32'(imem_we), 32'd0);
      check({tag, "_addr"}, 32'(imem_addr), 32'd0);
      check({tag, "_data"}, imem_wdata, 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_err"}, 32'(err), 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; base_addr = '0; count = '0;
      req_valid = 1'b0; req_kind = '0; req_rs = '0; req_rt = '0; req_rd = '0; req_imm = '0;
      tick(); tick();
      check_all_zero("reset");
      rst = 1'b0;
      tick();

      // Stray request while idle has no effect
      send(K_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
      tick();
      check("idle_req_we", 32'(imem_we), 32'd0);
      check("idle_req_busy", 32'(busy), 32'd0);
      req_valid = 1'b0;

      // Back-to-back ADD, LW, J from 0x10
      begin_session(8'h10, 8'd3);
      check("s1_busy", 32'(busy), 32'd1);
      check("s1_ready", 32'(req_ready), 32'd1);
      send(K_ADD, 5'd1, 5'd2, 5'd3, 26'h3FFFFFF);
      tick();
      check_write("s1_w0", 8'h10, 32'h0022_1820);
      send(K_LW, 5'd4, 5'd5, 5'd31, 26'h10);
      tick();
      check_write("s1_w1", 8'h11, 32'h8C85_0010);
      send(K_J, 5'd7, 5'd7, 5'd7, 26'h40);
      tick();
      check_write("s1_w2", 8'h12, 32'h0800_0040);
      check("s1_ready_end", 32'(req_ready), 32'd0);
      req_valid = 1'b0;
      tick();
      check("s1_done", 32'(done), 32'd1);
      check("s1_we_off", 32'(imem_we), 32'd0);
      check("s1_busy_done", 32'(busy), 32'd1);
      tick();
      check("s1_done_off", 32'(done), 32'd0);
      check("s1_idle", 32'(busy), 32'd0);
      check("s1_addr_hold", 32'(imem_addr), 32'h12);
      check("s1_data_hold", imem_wdata, 32'h0800_0040);

      // Address wrap 0xFF -> 0x00
      begin_session(8'hFF, 8'd2);
      send(K_SW, 5'd29, 5'd9, 5'd0, 26'hFFFC);
      tick();
      check_write("s2_w0", 8'hFF, 32'hAFA9_FFFC);
      send(K_XOR, 5'd2, 5'd3, 5'd1, 26'd0);
      tick();
      check_write("s2_w1", 8'h00, 32'h0043_0826);
      check("s2_err", 32'(err), 32'd0);
      req_valid = 1'b0;
      tick();
      check("s2_done", 32'(done), 32'd1);
      tick();

      // Gapped requests: valid on cycles 0 and 3
      begin_session(8'h30, 8'd2);
      send(K_ADD, 5'd1, 5'd1, 5'd1, 26'd0);
      tick();
      check_write("s3_c1", 8'h30, 32'h0021_0820);
      req_valid = 1'b0;
      tick();
      check("s3_c2_we", 32'(imem_we), 32'd0);
      tick();
      check("s3_c3_we", 32'(imem_we), 32'd0);
      check("s3_c3_ready", 32'(req_ready), 32'd1);
      send(K_OR, 5'd2, 5'd2, 5'd2, 26'd0);
      tick();
      check_write("s3_c4", 8'h31, 32'h0042_1025);
      check("s3_c4_ready", 32'(req_ready), 32'd0);
      tick();
      check("s3_c5_we", 32'(imem_we), 32'd0);
      check("s3_c5_done", 32'(done), 32'd1);
      req_valid = 1'b0;
      tick();

      // Oversized LW offset -> NOP and sticky err; start while busy is ignored
      begin_session(8'h20, 8'd2);
      send(K_LW, 5'd1, 5'd2, 5'd0, 26'h10004);
      tick();
      check_write("s4_w0", 8'h20, 32'h0000_0000);
      check("s4_err_set", 32'(err), 32'd1);
      send(K_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
      start = 1'b1; base_addr = 8'h80; count = 8'd5;
      tick();
      start = 1'b0;
      check_write("s4_w1", 8'h21, 32'h0022_1820);
      check("s4_err_hold", 32'(err), 32'd1);
      req_valid = 1'b0;
      tick();
      check("s4_done", 32'(done), 32'd1);
      tick();
      check("s4_idle", 32'(busy), 32'd0);
      check("s4_err_sticky", 32'(err), 32'd1);

      // Zero-length session
      begin_session(8'h55, 8'd0);
      check("s5_done", 32'(done), 32'd1);
      check("s5_we", 32'(imem_we), 32'd0);
      check("s5_err_clr", 32'(err), 32'd0);
      check("s5_ready", 32'(req_ready), 32'd0);
      tick();
      check("s5_done_off", 32'(done), 32'd0);
      check("s5_idle", 32'(busy), 32'd0);

      // Async reset after 2 of 4 writes, then a fresh session
      begin_session(8'h40, 8'd4);
      send(K_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
      tick();
      check_write("s6_w0", 8'h40, 32'h0022_1820);
      tick();
      check_write("s6_w1", 8'h41, 32'h0022_1820);
      rst = 1'b1;
      #1;
      check_all_zero("s6_rst");
      req_valid = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      check("s6_after_we", 32'(imem_we), 32'd0);
      begin_session(8'h50, 8'd1);
      send(K_AND, 5'd8, 5'd9, 5'd7, 26'd0);
      tick();
      check_write("s6_new", 8'h50, 32'h0109_3824);
      req_valid = 1'b0;
      tick();
      check("s6_done", 32'(done), 32'd1);
      tick();
      check("s6_idle", 32'(busy), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
